// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: 2-bit branch-predictor counter states.
package rv32i_types;

    typedef enum logic [1:0] {
        STRONG_NT = 2'd0,
        WEAK_NT   = 2'd1,
        WEAK_T    = 2'd2,
        STRONG_T  = 2'd3
    } bp_ctr_t;

    localparam bp_ctr_t BP_CTR_RESET = WEAK_NT;

endpackage

// File: rtl/bp_sat_ctr.sv
// Next-state logic for one 2-bit saturating predictor counter.
import rv32i_types::*;

module bp_sat_ctr (
    input  bp_ctr_t i_state,
    input  logic    i_taken,
    output bp_ctr_t o_next
);

    // Step one state toward the resolved outcome, clamping at both ends.
    always_comb begin
        o_next = BP_CTR_RESET;
        case (i_state)
            STRONG_NT: o_next = i_taken ? WEAK_NT  : STRONG_NT;
            WEAK_NT:   o_next = i_taken ? WEAK_T   : STRONG_NT;
            WEAK_T:    o_next = i_taken ? STRONG_T : WEAK_NT;
            STRONG_T:  o_next = i_taken ? STRONG_T : WEAK_T;
            default:   o_next = BP_CTR_RESET;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Gshare-style branch predictor: flop-based table of 2-bit counters indexed by PC xor global history.
import rv32i_types::*;

module branch_predictor #(
    parameter int BHT_IDX_BITS = 5,
    parameter int GHR_BITS     = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             pred_pc,
    output logic                    pred_taken,
    output logic [BHT_IDX_BITS-1:0] pred_idx,
    input  logic                    upd_valid,
    input  logic [BHT_IDX_BITS-1:0] upd_idx,
    input  logic                    upd_br_en,
    input  logic                    upd_pred_taken,
    output logic                    mispredict,
    output logic [31:0]             br_total,
    output logic [31:0]             br_miss
);

    localparam int BHT_ENTRIES = 1 << BHT_IDX_BITS;

    bp_ctr_t                 r_bht [BHT_ENTRIES];
    logic [GHR_BITS-1:0]     r_ghr;
    logic                    r_mispredict;
    logic [31:0]             r_br_total;
    logic [31:0]             r_br_miss;

    logic [BHT_IDX_BITS-1:0] w_pred_idx;
    bp_ctr_t                 w_pred_ctr;
    bp_ctr_t                 w_ctr_next;
    logic [GHR_BITS-1:0]     w_ghr_next;
    logic                    w_miss;
    logic                    w_unused_pc;

    assign w_unused_pc = ^{pred_pc[31:BHT_IDX_BITS+2], pred_pc[1:0]};
    assign w_pred_idx  = pred_pc[BHT_IDX_BITS+1:2] ^ BHT_IDX_BITS'(r_ghr);
    // No bypass: a same-cycle update to this entry shows up one cycle later.
    assign w_pred_ctr  = r_bht[w_pred_idx];
    assign pred_taken  = w_pred_ctr[1];
    assign pred_idx    = w_pred_idx;
    assign w_miss      = upd_valid & (upd_br_en != upd_pred_taken);

    assign mispredict  = r_mispredict;
    assign br_total    = r_br_total;
    assign br_miss     = r_br_miss;

    bp_sat_ctr u_sat_ctr (
        .i_state (r_bht[upd_idx]),
        .i_taken (upd_br_en),
        .o_next  (w_ctr_next)
    );

    generate
        if (GHR_BITS == 1) begin : g_ghr_one
            assign w_ghr_next = upd_br_en;
        end else begin : g_ghr_shift
            assign w_ghr_next = {r_ghr[GHR_BITS-2:0], upd_br_en};
        end
    endgenerate

    // Counter table: every entry is a flop so reset clears it asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_bht[i] <= BP_CTR_RESET;
            end
        end else if (upd_valid) begin
            r_bht[upd_idx] <= w_ctr_next;
        end
    end

    // Non-speculative history, mispredict pulse and branch statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ghr        <= '0;
            r_mispredict <= 1'b0;
            r_br_total   <= 32'd0;
            r_br_miss    <= 32'd0;
        end else begin
            r_mispredict <= w_miss;
            if (upd_valid) begin
                r_ghr      <= w_ghr_next;
                r_br_total <= r_br_total + 32'd1;
            end
            if (w_miss) begin
                r_br_miss <= r_br_miss + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed steps push expectations, a monitor checks them.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic [4:0]  pred_idx;
    logic        upd_valid;
    logic [4:0]  upd_idx;
    logic        upd_br_en;
    logic        upd_pred_taken;
    logic        mispredict;
    logic [31:0] br_total;
    logic [31:0] br_miss;

    typedef struct {
        int          at_cyc;
        string       name;
        logic        taken;
        logic [4:0]  idx;
        logic        misp;
        logic [31:0] tot;
        logic [31:0] miss;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   total  = 0;
    int   bad    = 0;
    bit   done   = 1'b0;

    branch_predictor #(.BHT_IDX_BITS(5), .GHR_BITS(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .pred_pc        (pred_pc),
        .pred_taken     (pred_taken),
        .pred_idx       (pred_idx),
        .upd_valid      (upd_valid),
        .upd_idx        (upd_idx),
        .upd_br_en      (upd_br_en),
        .upd_pred_taken (upd_pred_taken),
        .mispredict     (mispredict),
        .br_total       (br_total),
        .br_miss        (br_miss)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Drive one cycle of inputs and queue what the outputs must show this cycle.
    task automatic step(input string nm, input logic r, input logic [31:0] pc,
                        input logic uv, input logic [4:0] ui, input logic br, input logic pt,
                        input logic e_taken, input logic [4:0] e_idx, input logic e_misp,
                        input logic [31:0] e_tot, input logic [31:0] e_miss);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; pred_pc = pc; upd_valid = uv; upd_idx = ui;
        upd_br_en = br; upd_pred_taken = pt;
        e.at_cyc = cyc; e.name = nm; e.taken = e_taken; e.idx = e_idx;
        e.misp = e_misp; e.tot = e_tot; e.miss = e_miss;
        q.push_back(e);
    endtask

    // Monitor: on each falling edge compare every expectation due this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].at_cyc <= cyc) begin
                e = q.pop_front();
                total++;
                if (e.at_cyc != cyc) begin
                    bad++;
                    $display("FAIL %s: stale expectation cyc=%0d now=%0d", e.name, e.at_cyc, cyc);
                end else if (pred_taken !== e.taken || pred_idx !== e.idx || mispredict !== e.misp ||
                             br_total !== e.tot || br_miss !== e.miss) begin
                    bad++;
                    $display("FAIL %s: got taken=%0b idx=%h misp=%0b tot=%h miss=%h want taken=%0b idx=%h misp=%0b tot=%h miss=%h",
                             e.name, pred_taken, pred_idx, mispredict, br_total, br_miss,
                             e.taken, e.idx, e.misp, e.tot, e.miss);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; pred_pc = 32'h0000_0040; upd_valid = 1'b0; upd_idx = 5'h00;
        upd_br_en = 1'b0; upd_pred_taken = 1'b0;
        repeat (2) @(posedge clk);
        //    name        rst  pc            uv    idx    br    pt    taken idx    misp  tot           miss
        step("reset",     1'b0, 32'h40, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 5'h10, 1'b0, 32'd0,  32'd0);
        step("sat_t1",    1'b0, 32'h40, 1'b1, 5'h10, 1'b1, 1'b1, 1'b0, 5'h10, 1'b0, 32'd0,  32'd0);
        step("sat_t2",    1'b0, 32'h40, 1'b1, 5'h10, 1'b1, 1'b1, 1'b0, 5'h11, 1'b0, 32'd1,  32'd0);
        step("sat_t3",    1'b0, 32'h40, 1'b1, 5'h10, 1'b1, 1'b1, 1'b0, 5'h13, 1'b0, 32'd2,  32'd0);
        step("sat_t4",    1'b0, 32'h40, 1'b1, 5'h10, 1'b1, 1'b1, 1'b0, 5'h17, 1'b0, 32'd3,  32'd0);
        step("clr_ghr1",  1'b0, 32'h40, 1'b1, 5'h01, 1'b0, 1'b0, 1'b0, 5'h1f, 1'b0, 32'd4,  32'd0);
        step("clr_ghr2",  1'b0, 32'h40, 1'b1, 5'h01, 1'b0, 1'b0, 1'b0, 5'h0e, 1'b0, 32'd5,  32'd0);
        step("clr_ghr3",  1'b0, 32'h40, 1'b1, 5'h01, 1'b0, 1'b0, 1'b0, 5'h0c, 1'b0, 32'd6,  32'd0);
        step("clr_ghr4",  1'b0, 32'h40, 1'b1, 5'h01, 1'b0, 1'b0, 1'b0, 5'h08, 1'b0, 32'd7,  32'd0);
        step("clr_ghr5",  1'b0, 32'h40, 1'b1, 5'h01, 1'b0, 1'b0, 1'b0, 5'h00, 1'b0, 32'd8,  32'd0);
        step("strong_t",  1'b0, 32'h40, 1'b0, 5'h00, 1'b0, 1'b0, 1'b1, 5'h10, 1'b0, 32'd9,  32'd0);
        step("dec_nt",    1'b0, 32'h40, 1'b1, 5'h10, 1'b0, 1'b1, 1'b1, 5'h10, 1'b0, 32'd9,  32'd0);
        step("weak_t",    1'b0, 32'h40, 1'b0, 5'h10, 1'b0, 1'b1, 1'b1, 5'h10, 1'b1, 32'd10, 32'd1);
        step("idle_junk", 1'b0, 32'h40, 1'b0, 5'h10, 1'b0, 1'b1, 1'b1, 5'h10, 1'b0, 32'd10, 32'd1);
        step("idle_hold", 1'b0, 32'h40, 1'b0, 5'h00, 1'b0, 1'b0, 1'b1, 5'h10, 1'b0, 32'd10, 32'd1);
        step("rst_mid",   1'b1, 32'h40, 1'b1, 5'h10, 1'b1, 1'b0, 1'b0, 5'h10, 1'b0, 32'd0,  32'd0);
        step("rst_rel",   1'b0, 32'h40, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 5'h10, 1'b0, 32'd0,  32'd0);
        step("misp_upd",  1'b0, 32'h40, 1'b1, 5'h10, 1'b1, 1'b0, 1'b0, 5'h10, 1'b0, 32'd0,  32'd0);
        step("misp_hi",   1'b0, 32'h40, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 5'h11, 1'b1, 32'd1,  32'd1);
        step("misp_lo",   1'b0, 32'h40, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 5'h11, 1'b0, 32'd1,  32'd1);
        step("rst2",      1'b1, 32'h40, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 5'h10, 1'b0, 32'd0,  32'd0);
        step("hist_1",    1'b0, 32'h40, 1'b1, 5'h02, 1'b1, 1'b1, 1'b0, 5'h10, 1'b0, 32'd0,  32'd0);
        step("hist_0",    1'b0, 32'h40, 1'b1, 5'h02, 1'b0, 1'b0, 1'b0, 5'h11, 1'b0, 32'd1,  32'd0);
        step("hist_1b",   1'b0, 32'h40, 1'b1, 5'h02, 1'b1, 1'b1, 1'b0, 5'h12, 1'b0, 32'd2,  32'd0);
        step("hist_idx",  1'b0, 32'h40, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 5'h15, 1'b0, 32'd3,  32'd0);
        step("coll_old",  1'b0, 32'h40, 1'b1, 5'h15, 1'b1, 1'b1, 1'b0, 5'h15, 1'b0, 32'd3,  32'd0);
        step("coll_new",  1'b0, 32'h78, 1'b0, 5'h00, 1'b0, 1'b0, 1'b1, 5'h15, 1'b0, 32'd4,  32'd0);
        step("wrap_pre",  1'b0, 32'h78, 1'b1, 5'h03, 1'b0, 1'b0, 1'b1, 5'h15, 1'b0, 32'hFFFF_FFFF, 32'd0);
        step("wrap_post", 1'b0, 32'h78, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 5'h08, 1'b0, 32'd0,  32'd0);
        repeat (2) @(posedge clk);
        done = 1'b1;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations never checked, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Preload the branch counter just before the wrap step's clock edge.
    initial begin
        wait (cyc == 30);
        #2;
        force dut.r_br_total = 32'hFFFF_FFFF;
        #1;
        release dut.r_br_total;
    end

    initial begin
        #100000;
        if (!done) begin
            $display("FAIL timeout: bench did not finish, total=%0d", total);
            $fatal(1);
        end
    end

endmodule
